uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 131 +++++++++++++
 tb/tb_uart_tx_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Two-requester UART transmitter: round-robin byte acceptance on baud ticks,
// serialises start/data(LSB first)/stop, and defers baud changes until the line is idle.
module uart_tx_sched #(
    parameter int         NBITS    = 8,
    parameter logic [1:0] RST_BAUD = 2'b11
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             baud_tick,
    input  logic [1:0]       req,
    input  logic [NBITS-1:0] data0,
    input  logic [NBITS-1:0] data1,
    output logic [1:0]       grant,
    input  logic             cfg_wr,
    input  logic [1:0]       cfg_baud,
    output logic [1:0]       sel_baud,
    output logic             cfg_pend,
    output logic             txd,
    output logic             busy,
    output logic             owner,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int            CW       = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [NBITS-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic             last_srv;
    logic [1:0]       pend_baud;
    logic             accept;
    logic             winner;

    // Handshake: requester i holds req[i] with its byte on data<i>; the byte is
    // taken on the single cycle grant[i]=1, after which req[i] may drop or change.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        grant     = 2'b00;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_srv;
            default: winner = 1'b0;
        endcase
        case (state)
            IDLE: begin
                // A config write in the same cycle takes priority over acceptance.
                if (!rst && baud_tick && (req != 2'b00) && !cfg_pend && !cfg_wr) begin
                    accept    = 1'b1;
                    state_nxt = START;
                    grant     = winner ? 2'b10 : 2'b01;
                end
            end
            START: if (baud_tick) state_nxt = DATA;
            DATA:  if (baud_tick && (bit_cnt == LAST_BIT)) state_nxt = STOP;
            STOP:  if (baud_tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            txd       <= 1'b1;
            shreg     <= '0;
            bit_cnt   <= '0;
            owner     <= 1'b0;
            last_srv  <= 1'b1;
            sel_baud  <= RST_BAUD;
            cfg_pend  <= 1'b0;
            pend_baud <= RST_BAUD;
        end else begin
            if (accept) begin
                shreg    <= winner ? data1 : data0;
                owner    <= winner;
                last_srv <= winner;
                txd      <= 1'b0;
            end else if (baud_tick) begin
                case (state)
                    START: begin
                        txd     <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        if (bit_cnt == LAST_BIT) begin
                            txd <= 1'b1;
                        end else begin
                            txd     <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            // A write landing on the STOP->IDLE edge supersedes any stored value.
            if (state == STOP && baud_tick) begin
                if (cfg_wr)        sel_baud <= cfg_baud;
                else if (cfg_pend) sel_baud <= pend_baud;
                cfg_pend <= 1'b0;
            end else if (cfg_wr) begin
                if (state == IDLE) begin
                    sel_baud <= cfg_baud;
                end else begin
                    pend_baud <= cfg_baud;
                    cfg_pend  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: scenario tasks plus a line-decoding scoreboard
// that pops the expected {owner, byte} for every frame seen on txd.
module tb_uart_tx_sched;

    localparam int NBITS  = 8;
    localparam int TICK_P = 16;

    logic             sys_clk = 1'b0;
    logic             rst = 1'b1;
    logic             baud_tick = 1'b0;
    logic [1:0]       req = 2'b00;
    logic [NBITS-1:0] data0 = '0;
    logic [NBITS-1:0] data1 = '0;
    logic             cfg_wr = 1'b0;
    logic [1:0]       cfg_baud = 2'b00;
    logic [1:0]       grant;
    logic [1:0]       sel_baud;
    logic             cfg_pend;
    logic             txd;
    logic             busy;
    logic             owner;
    logic [1:0]       state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int tick_cnt = 0;
    logic [NBITS:0] exp_q[$];

    logic             rx_active = 1'b0;
    int               rx_bit = 0;
    logic [NBITS-1:0] rx_data = '0;
    logic             rx_owner = 1'b0;
    logic [NBITS:0]   rx_exp;

    uart_tx_sched #(.NBITS(NBITS), .RST_BAUD(2'b11)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .grant     (grant),
        .cfg_wr    (cfg_wr),
        .cfg_baud  (cfg_baud),
        .sel_baud  (sel_baud),
        .cfg_pend  (cfg_pend),
        .txd       (txd),
        .busy      (busy),
        .owner     (owner),
        .state_dbg (state_dbg)
    );

    // Clock and baud generator
    always #5 sys_clk = ~sys_clk;

    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            tick_cnt  = (tick_cnt + 1) % TICK_P;
            baud_tick = (tick_cnt == 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Grant legality and line decoding; txd sampled at each tick is the bit just completed
    always @(negedge sys_clk) begin
        if (grant !== 2'b00) begin
            n_checks++;
            if (busy !== 1'b0 || (grant & ~req) !== 2'b00 || !(grant == 2'b01 || grant == 2'b10))
                $display("FAIL grant_legal: grant=%b req=%b busy=%b, required one-hot within req while idle",
                         grant, req, busy);
            else
                n_pass++;
        end
        if (rst) begin
            rx_active = 1'b0;
        end else if (baud_tick) begin
            if (!rx_active) begin
                if (txd === 1'b0) begin
                    rx_active = 1'b1;
                    rx_bit    = 0;
                    rx_owner  = owner;
                end
            end else if (rx_bit < NBITS) begin
                rx_data[rx_bit] = txd;
                rx_bit++;
            end else begin
                rx_active = 1'b0;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL frame_unexpected: got owner=%b data=%h, required no frame", rx_owner, rx_data);
                end else begin
                    rx_exp = exp_q.pop_front();
                    if (txd !== 1'b1 || {rx_owner, rx_data} !== rx_exp)
                        $display("FAIL frame: got owner=%b data=%h stop=%b, required owner=%b data=%h stop=1",
                                 rx_owner, rx_data, txd, rx_exp[NBITS], rx_exp[NBITS-1:0]);
                    else
                        n_pass++;
                end
            end
        end
    end

    // Driver tasks
    task automatic apply_reset();
        @(posedge sys_clk); #1 rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_grant(input int budget, output int cycles, output logic [1:0] g);
        cycles = 0;
        g      = 2'b00;
        while (cycles < budget && g == 2'b00) begin
            @(negedge sys_clk);
            cycles++;
            if (grant !== 2'b00) g = grant;
        end
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (busy !== 1'b0 && c < budget) begin
            @(negedge sys_clk);
            c++;
        end
    endtask

    task automatic wait_pre_tick();
        int c;
        c = 0;
        while (tick_cnt != TICK_P - 1 && c < 2 * TICK_P) begin
            @(negedge sys_clk);
            c++;
        end
    endtask

    // Scenarios
    task automatic test_reset();
        repeat (2) @(negedge sys_clk);
        n_checks++; if (txd !== 1'b1)         $display("FAIL reset_txd: got %b, required 1", txd); else n_pass++;
        n_checks++; if (busy !== 1'b0)        $display("FAIL reset_busy: got %b, required 0", busy); else n_pass++;
        n_checks++; if (grant !== 2'b00)      $display("FAIL reset_grant: got %b, required 00", grant); else n_pass++;
        n_checks++; if (owner !== 1'b0)       $display("FAIL reset_owner: got %b, required 0", owner); else n_pass++;
        n_checks++; if (cfg_pend !== 1'b0)    $display("FAIL reset_cfg_pend: got %b, required 0", cfg_pend); else n_pass++;
        n_checks++; if (sel_baud !== 2'b11)   $display("FAIL reset_sel_baud: got %b, required 11", sel_baud); else n_pass++;
        n_checks++; if (state_dbg !== 2'd0)   $display("FAIL reset_state: got %0d, required 0", state_dbg); else n_pass++;
        @(posedge sys_clk); #1 rst = 1'b0;
    endtask

    task automatic test_single_frame();
        logic [9:0] line_bits;
        logic [1:0] g;
        logic       ok;
        int         cyc;
        line_bits = {1'b1, 8'hA5, 1'b0};
        @(posedge sys_clk); #1;
        data0 = 8'hA5;
        req   = 2'b01;
        exp_q.push_back({1'b0, 8'hA5});
        wait_grant(40, cyc, g);
        n_checks++;
        if (g !== 2'b01 || baud_tick !== 1'b1)
            $display("FAIL single_grant: grant=%b tick=%b, required 01 on a tick", g, baud_tick);
        else n_pass++;
        @(posedge sys_clk); #1 req = 2'b00;
        for (int p = 0; p < 10; p++) begin
            ok = 1'b1;
            for (int c = 0; c < TICK_P; c++) begin
                @(negedge sys_clk);
                if (txd !== line_bits[p]) ok = 1'b0;
            end
            n_checks++;
            if (!ok) $display("FAIL single_bit%0d: txd left %b within the bit period, required steady %b", p, txd, line_bits[p]);
            else n_pass++;
        end
        n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_last: got %b, required 1 until 10th tick", busy); else n_pass++;
        @(negedge sys_clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_fall: got %b, required 0 after 10th tick", busy); else n_pass++;
        n_checks++; if (txd !== 1'b1)  $display("FAIL single_idle_txd: got %b, required 1", txd); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g[3];
        logic [1:0] g;
        int         cyc;
        exp_g = '{2'b01, 2'b10, 2'b01};
        apply_reset();
        @(posedge sys_clk); #1;
        data0 = 8'($urandom_range(0, 255));
        data1 = 8'($urandom_range(0, 255));
        req   = 2'b11;
        exp_q.push_back({1'b0, data0});
        exp_q.push_back({1'b1, data1});
        exp_q.push_back({1'b0, data0});
        for (int k = 0; k < 3; k++) begin
            wait_grant((k == 0) ? 40 : 200, cyc, g);
            n_checks++;
            if (g !== exp_g[k]) $display("FAIL rr_grant%0d: got %b, required %b", k, g, exp_g[k]);
            else n_pass++;
            if (k > 0) begin
                n_checks++;
                if (cyc !== 175) $display("FAIL rr_gap%0d: got %0d cycles, required 175", k, cyc);
                else n_pass++;
            end
            @(negedge sys_clk);
            n_checks++;
            if (owner !== exp_g[k][1]) $display("FAIL rr_owner%0d: got %b, required %b", k, owner, exp_g[k][1]);
            else n_pass++;
        end
        @(posedge sys_clk); #1 req = 2'b00;
        wait_idle(200);
    endtask

    task automatic test_cfg_pending();
        logic [1:0] g;
        logic       ok;
        int         cyc;
        @(posedge sys_clk); #1;
        data0 = 8'($urandom_range(0, 255));
        req   = 2'b01;
        exp_q.push_back({1'b0, data0});
        wait_grant(40, cyc, g);
        n_checks++; if (g !== 2'b01) $display("FAIL cfgp_grant: got %b, required 01", g); else n_pass++;
        @(posedge sys_clk); #1 req = 2'b00;
        repeat (40) @(negedge sys_clk);
        @(posedge sys_clk); #1 cfg_wr = 1'b1; cfg_baud = 2'b01;
        @(posedge sys_clk); #1 cfg_wr = 1'b0;
        @(negedge sys_clk);
        n_checks++; if (cfg_pend !== 1'b1)  $display("FAIL cfgp_pend_set: got %b, required 1", cfg_pend); else n_pass++;
        n_checks++; if (sel_baud !== 2'b11) $display("FAIL cfgp_sel_held: got %b, required 11", sel_baud); else n_pass++;
        repeat (16) @(negedge sys_clk);
        @(posedge sys_clk); #1;
        cfg_wr   = 1'b1;
        cfg_baud = 2'b00;
        req      = 2'b01;
        data0    = 8'($urandom_range(0, 255));
        exp_q.push_back({1'b0, data0});
        @(posedge sys_clk); #1 cfg_wr = 1'b0;
        ok  = 1'b1;
        cyc = 0;
        do begin
            @(negedge sys_clk);
            cyc++;
            if (busy === 1'b1 && (sel_baud !== 2'b11 || cfg_pend !== 1'b1)) ok = 1'b0;
        end while (busy === 1'b1 && cyc < 200);
        n_checks++; if (!ok)               $display("FAIL cfgp_hold_busy: sel=%b pend=%b, required 11/1 while busy", sel_baud, cfg_pend); else n_pass++;
        n_checks++; if (busy !== 1'b0)     $display("FAIL cfgp_idle: busy=%b, required 0 within budget", busy); else n_pass++;
        n_checks++; if (sel_baud !== 2'b00) $display("FAIL cfgp_applied: got %b, required 00", sel_baud); else n_pass++;
        n_checks++; if (cfg_pend !== 1'b0) $display("FAIL cfgp_pend_clr: got %b, required 0", cfg_pend); else n_pass++;
        wait_grant(40, cyc, g);
        n_checks++;
        if (g !== 2'b01 || cyc !== 15) $display("FAIL cfgp_next_grant: grant=%b after %0d cycles, required 01 after 15", g, cyc);
        else n_pass++;
        @(posedge sys_clk); #1 req = 2'b00;
        wait_idle(200);
    endtask

    task automatic test_cfg_idle();
        logic [1:0] g;
        int         cyc;
        wait_pre_tick();
        @(posedge sys_clk); #1;
        req      = 2'b01;
        cfg_wr   = 1'b1;
        cfg_baud = 2'b10;
        data0    = 8'($urandom_range(0, 255));
        exp_q.push_back({1'b0, data0});
        @(negedge sys_clk);
        n_checks++;
        if (baud_tick !== 1'b1 || grant !== 2'b00)
            $display("FAIL cfgi_blocked: tick=%b grant=%b, required tick=1 grant=00", baud_tick, grant);
        else n_pass++;
        @(posedge sys_clk); #1 cfg_wr = 1'b0;
        @(negedge sys_clk);
        n_checks++; if (sel_baud !== 2'b10) $display("FAIL cfgi_sel: got %b, required 10", sel_baud); else n_pass++;
        n_checks++; if (cfg_pend !== 1'b0)  $display("FAIL cfgi_pend: got %b, required 0", cfg_pend); else n_pass++;
        wait_grant(40, cyc, g);
        n_checks++;
        if (g !== 2'b01 || cyc !== 15) $display("FAIL cfgi_next_grant: grant=%b after %0d cycles, required 01 after 15", g, cyc);
        else n_pass++;
        @(posedge sys_clk); #1 req = 2'b00;
        wait_idle(200);
    endtask

    task automatic test_reset_mid_frame();
        logic [1:0] g;
        logic       ok;
        int         cyc;
        @(posedge sys_clk); #1;
        data0 = 8'($urandom_range(0, 255));
        req   = 2'b01;
        wait_grant(40, cyc, g);
        n_checks++; if (g !== 2'b01) $display("FAIL rmid_grant: got %b, required 01", g); else n_pass++;
        repeat (88) @(negedge sys_clk);
        @(posedge sys_clk); #1 rst = 1'b1;
        #1;
        n_checks++; if (txd !== 1'b1)       $display("FAIL rmid_txd: got %b, required 1", txd); else n_pass++;
        n_checks++; if (busy !== 1'b0)      $display("FAIL rmid_busy: got %b, required 0", busy); else n_pass++;
        n_checks++; if (sel_baud !== 2'b11) $display("FAIL rmid_sel: got %b, required 11", sel_baud); else n_pass++;
        n_checks++; if (state_dbg !== 2'd0) $display("FAIL rmid_state: got %0d, required 0", state_dbg); else n_pass++;
        ok = 1'b1;
        repeat (40) begin
            @(negedge sys_clk);
            if (grant !== 2'b00 || txd !== 1'b1) ok = 1'b0;
        end
        n_checks++; if (!ok) $display("FAIL rmid_hold: grant=%b txd=%b, required 00/1 during reset", grant, txd); else n_pass++;
        data0 = 8'($urandom_range(0, 255));
        exp_q.push_back({1'b0, data0});
        @(posedge sys_clk); #1 rst = 1'b0;
        wait_grant(40, cyc, g);
        n_checks++;
        if (g !== 2'b01 || baud_tick !== 1'b1) $display("FAIL rmid_regrant: grant=%b tick=%b, required 01 on a tick", g, baud_tick);
        else n_pass++;
        @(posedge sys_clk); #1 req = 2'b00;
        ok = 1'b1;
        repeat (TICK_P) begin
            @(negedge sys_clk);
            if (txd !== 1'b0) ok = 1'b0;
        end
        n_checks++; if (!ok) $display("FAIL rmid_start_bit: txd=%b, required 0 for a full bit period", txd); else n_pass++;
        wait_idle(200);
    endtask

    initial begin
        int cyc;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_cfg_pending();
        test_cfg_idle();
        test_reset_mid_frame();
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 400) begin
            @(negedge sys_clk);
            cyc++;
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL drain: %0d frames outstanding, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
